// File: rtl/chip_bus_arbiter_if.sv
// chip_bus_arbiter_if
//   Bundles the per-slot DMA requests, override/nasty controls and the
//   registered grant/owner/position outputs of the chip bus arbiter.
//   master : requester side (drives requests, observes grants)
//   slave  : arbiter side   (observes requests, drives grants)
interface chip_bus_arbiter_if;
  logic       _OVR;
  logic       REQ_DSK;
  logic [3:0] REQ_AUD;
  logic       REQ_BPL;
  logic       REQ_COP;
  logic       REQ_BLT;
  logic       REQ_CPU;
  logic       BLT_NASTY;

  logic       GNT_REF;
  logic       GNT_DSK;
  logic [3:0] GNT_AUD;
  logic       GNT_BPL;
  logic       GNT_COP;
  logic       GNT_BLT;
  logic       GNT_CPU;
  logic [3:0] OWNER;
  logic [7:0] HPOS;
  logic       LINE_END;

  modport master (
    output _OVR, REQ_DSK, REQ_AUD, REQ_BPL, REQ_COP, REQ_BLT, REQ_CPU, BLT_NASTY,
    input  GNT_REF, GNT_DSK, GNT_AUD, GNT_BPL, GNT_COP, GNT_BLT, GNT_CPU,
           OWNER, HPOS, LINE_END
  );

  modport slave (
    input  _OVR, REQ_DSK, REQ_AUD, REQ_BPL, REQ_COP, REQ_BLT, REQ_CPU, BLT_NASTY,
    output GNT_REF, GNT_DSK, GNT_AUD, GNT_BPL, GNT_COP, GNT_BLT, GNT_CPU,
           OWNER, HPOS, LINE_END
  );
endinterface

// File: rtl/chip_bus_arbiter.sv
// chip_bus_arbiter
//   Slot-based memory bus arbiter. A free-running horizontal slot counter
//   selects each slot's class (refresh, disk, audio, free); the winner is
//   decided combinationally and all outputs are registered together, so a
//   grant appears one cycle after the slot is evaluated, tagged with HPOS.
//   Ports:
//     CLK  : slot clock, one slot per rising edge
//     _RST : asynchronous active-low reset
//     bus  : requests/controls in, grants/OWNER/HPOS/LINE_END out
module chip_bus_arbiter #(
  parameter int HSLOTS      = 227,
  parameter int NASTY_LIMIT = 3
) (
  input  logic               CLK,
  input  logic               _RST,
  chip_bus_arbiter_if.slave  bus
);

  localparam int            SW    = (NASTY_LIMIT < 2) ? 1 : $clog2(NASTY_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(NASTY_LIMIT);

  localparam logic [3:0] OWN_IDLE = 4'd0;
  localparam logic [3:0] OWN_REF  = 4'd1;
  localparam logic [3:0] OWN_DSK  = 4'd2;
  localparam logic [3:0] OWN_AUD0 = 4'd3;
  localparam logic [3:0] OWN_BPL  = 4'd7;
  localparam logic [3:0] OWN_COP  = 4'd8;
  localparam logic [3:0] OWN_BLT  = 4'd9;
  localparam logic [3:0] OWN_CPU  = 4'd10;

  logic [7:0]    hcnt_q, hcnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [3:0]    owner_q, owner_d;
  logic [10:1]   gnt_q, gnt_d;     // indexed by owner code
  logic [7:0]    hpos_q, hpos_d;
  logic          line_end_q, line_end_d;

  logic          last_slot, refresh_slot, disk_slot, aud_slot, free_slot, cpu_boost;

  always_comb begin
    last_slot    = (hcnt_q == 8'(HSLOTS - 1));
    hcnt_d       = last_slot ? 8'd0 : hcnt_q + 8'd1;
    hpos_d       = hcnt_q;
    line_end_d   = last_slot;

    refresh_slot = hcnt_q inside {8'h02, 8'h04, 8'h06, 8'h08};
    disk_slot    = hcnt_q inside {8'h0A, 8'h0C, 8'h0E};
    // 0x10,0x12,0x14,0x16: channel number sits in hcnt[2:1]
    aud_slot     = (hcnt_q[7:3] == 5'b00010) && !hcnt_q[0];
    // a starved CPU jumps ahead of a polite blitter for one free slot
    cpu_boost    = (starve_q == LIMIT) && !bus.BLT_NASTY;

    owner_d   = OWN_IDLE;
    free_slot = 1'b0;
    if (refresh_slot)
      owner_d = OWN_REF;
    else if (disk_slot && bus._OVR && bus.REQ_DSK)
      owner_d = OWN_DSK;
    else if (aud_slot && bus._OVR && bus.REQ_AUD[hcnt_q[2:1]])
      owner_d = OWN_AUD0 + {2'b00, hcnt_q[2:1]};
    else begin
      free_slot = 1'b1;
      if (!bus._OVR)                    owner_d = bus.REQ_CPU ? OWN_CPU : OWN_IDLE;
      else if (bus.REQ_BPL)             owner_d = OWN_BPL;
      else if (bus.REQ_COP)             owner_d = OWN_COP;
      else if (bus.REQ_CPU && cpu_boost) owner_d = OWN_CPU;
      else if (bus.REQ_BLT)             owner_d = OWN_BLT;
      else if (bus.REQ_CPU)             owner_d = OWN_CPU;
    end

    // starvation only accrues on free slots the blitter takes from a waiting CPU
    starve_d = starve_q;
    if (!bus._OVR)
      starve_d = '0;
    else if (free_slot) begin
      if (owner_d == OWN_CPU || !bus.REQ_CPU)
        starve_d = '0;
      else if (owner_d == OWN_BLT && starve_q != LIMIT)
        starve_d = starve_q + SW'(1);
    end

    for (int i = 1; i <= 10; i++)
      gnt_d[i] = (owner_d == 4'(i));
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      hcnt_q     <= '0;
      starve_q   <= '0;
      owner_q    <= '0;
      gnt_q      <= '0;
      hpos_q     <= '0;
      line_end_q <= 1'b0;
    end else begin
      hcnt_q     <= hcnt_d;
      starve_q   <= starve_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      hpos_q     <= hpos_d;
      line_end_q <= line_end_d;
    end
  end

  assign bus.GNT_REF  = gnt_q[1];
  assign bus.GNT_DSK  = gnt_q[2];
  assign bus.GNT_AUD  = gnt_q[6:3];
  assign bus.GNT_BPL  = gnt_q[7];
  assign bus.GNT_COP  = gnt_q[8];
  assign bus.GNT_BLT  = gnt_q[9];
  assign bus.GNT_CPU  = gnt_q[10];
  assign bus.OWNER    = owner_q;
  assign bus.HPOS     = hpos_q;
  assign bus.LINE_END = line_end_q;

endmodule

// File: doc/chip_bus_arbiter.md
CHIP_BUS_ARBITER -- requirements
Module: chip_bus_arbiter

Interface
REQ-001 Parameter HSLOTS, default 227, memory slots per horizontal line.
REQ-002 Parameter NASTY_LIMIT, default 3, consecutive denied CPU free slots before a non-nasty blitter yields.
REQ-003 CLK  in  1  slot clock; one memory slot per rising edge.
REQ-004 _RST  in  1  reset: one clock; reset is asynchronous and active-low.
REQ-005 _OVR  in  1  active-low override; suppresses all non-refresh DMA.
REQ-006 REQ_DSK  in  1  disk DMA request.
REQ-007 REQ_AUD  in  4  audio channel 0-3 DMA requests.
REQ-008 REQ_BPL, REQ_COP, REQ_BLT, REQ_CPU  in  1 each  bitplane, copper, blitter, CPU requests.
REQ-009 BLT_NASTY  in  1  blitter-nasty flag; 1 = blitter never yields to CPU.
REQ-010 GNT_REF, GNT_DSK, GNT_BPL, GNT_COP, GNT_BLT, GNT_CPU  out  1 each  registered grants.
REQ-011 GNT_AUD  out  4  registered audio grants.
REQ-012 OWNER  out  4  slot owner: 0 idle, 1 REF, 2 DSK, 3-6 AUD0-3, 7 BPL, 8 COP, 9 BLT, 10 CPU.
REQ-013 HPOS  out  8  slot number the current grant outputs refer to.
REQ-014 LINE_END  out  1  one-cycle pulse registered with the slot HSLOTS-1.

Function
REQ-015 Internal counter hcnt SHALL increment every CLK edge and wrap HSLOTS-1 -> 0.
REQ-016 Arbitration SHALL be combinational on hcnt and inputs; all outputs SHALL be registered together, giving grant latency of exactly one cycle; HPOS equals the arbitrated hcnt.
REQ-017 Grant outputs SHALL be one-hot or all-zero; OWNER SHALL match the asserted grant (0 when none).
REQ-018 Refresh slots 0x02, 0x04, 0x06, 0x08 SHALL always grant REF, regardless of any input.
REQ-019 Disk slots 0x0A, 0x0C, 0x0E SHALL grant DSK when REQ_DSK=1 and _OVR=1.
REQ-020 Audio slots 0x10, 0x12, 0x14, 0x16 SHALL grant AUD0..AUD3 respectively when the matching REQ_AUD bit=1 and _OVR=1.
REQ-021 Every other slot, and any disk/audio slot left unused, SHALL be a free slot.
REQ-022 Free slot priority SHALL be BPL > COP > BLT > CPU; no request -> OWNER 0.
REQ-023 Starve counter (saturating at NASTY_LIMIT) SHALL increment on each free slot where REQ_CPU=1 and BLT is granted; SHALL clear when CPU is granted or REQ_CPU=0 at a free slot.
REQ-024 When starve counter = NASTY_LIMIT and BLT_NASTY=0, CPU SHALL rank above BLT (still below BPL, COP) for the next free slot.
REQ-025 While _OVR=0: only REF and CPU SHALL be grantable; all free slots go to CPU when REQ_CPU=1; starve counter held at 0.
REQ-026 LINE_END SHALL be 1 exactly in the cycle HPOS = HSLOTS-1.
REQ-027 Requests changing between edges SHALL only affect the slot evaluated at the next edge; no grant is held across slots.

Reset
REQ-028 _RST low SHALL asynchronously clear hcnt, starve counter, all grants, OWNER, HPOS and LINE_END to 0.
REQ-029 Reset asserted mid-line SHALL abort the current slot immediately; no grant pulse SHALL survive reset.
REQ-030 After _RST release, the first CLK edge SHALL evaluate hcnt=0 (outputs HPOS=0 after that edge).

Verification
REQ-031 Reset release, all requests 0 -> HPOS counts 0..226 then 0; GNT_REF at HPOS 2,4,6,8 only; LINE_END once per 227 cycles.
REQ-032 REQ_BPL=REQ_COP=REQ_BLT=REQ_CPU=1 -> every free slot OWNER=7; slots 0x02-0x08 OWNER=1.
REQ-033 REQ_BLT=REQ_CPU=1, BLT_NASTY=0 -> three free-slot BLT grants then one CPU grant, pattern repeating; with BLT_NASTY=1 CPU never granted.
REQ-034 REQ_DSK=0, REQ_AUD=4'b0101, REQ_CPU=1 -> HPOS 0x0A-0x0E OWNER=10, 0x10 OWNER=3, 0x12 OWNER=10, 0x14 OWNER=5.
REQ-035 _OVR=0 with all requests 1 -> only OWNER 1 at refresh slots, OWNER 10 elsewhere; starve counter 0.
REQ-036 _RST pulsed low at HPOS 0x50 during BLT grant -> outputs 0 immediately; after release, HPOS restarts at 0.
